// File: rtl/sa_rr_scheduler_pkg.sv
// Shared router definitions for the switch allocator: port indices, index
// typedefs, default sizes and the pointer wrap helper.
package sa_rr_scheduler_pkg;

    localparam int NUM_PORTS_DEF = 5;
    localparam int NUM_VC_DEF    = 4;
    localparam int AGE_MAX_DEF   = 15;
    localparam int PORT_BITS_DEF = $clog2(NUM_PORTS_DEF);
    localparam int VC_BITS_DEF   = $clog2(NUM_VC_DEF);

    localparam logic [PORT_BITS_DEF-1:0] PORT_LOCAL = 3'd0;
    localparam logic [PORT_BITS_DEF-1:0] PORT_N     = 3'd1;
    localparam logic [PORT_BITS_DEF-1:0] PORT_S     = 3'd2;
    localparam logic [PORT_BITS_DEF-1:0] PORT_E     = 3'd3;
    localparam logic [PORT_BITS_DEF-1:0] PORT_W     = 3'd4;

    typedef logic [PORT_BITS_DEF-1:0] port_idx_t;
    typedef logic [VC_BITS_DEF-1:0]   vc_idx_t;

    // Round-robin pointer advance: one past the winner, wrapping at n.
    function automatic int wrap_inc(input int val, input int n);
        return ((val + 1) >= n) ? 0 : (val + 1);
    endfunction

endpackage

// File: rtl/sa_rr_scheduler_if.sv
// Request/grant bundle between VC allocation and the switch allocator.
// master drives requests and credits; slave (the allocator) drives grants.
interface sa_rr_scheduler_if
    import sa_rr_scheduler_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int NUM_VC    = NUM_VC_DEF
) ();
    localparam int PORT_BITS = $clog2(NUM_PORTS);
    localparam int VC_BITS   = $clog2(NUM_VC);

    logic [NUM_PORTS-1:0][NUM_VC-1:0]                req_valid;
    logic [NUM_PORTS-1:0][NUM_VC-1:0][PORT_BITS-1:0] req_port;
    logic [NUM_PORTS-1:0][NUM_VC-1:0][VC_BITS-1:0]   req_out_vc;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]                credit_avail;
    logic [NUM_PORTS-1:0]                            grant_valid;
    logic [NUM_PORTS-1:0][VC_BITS-1:0]               grant_vc;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]             grant_out_port;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]                credit_consume;

    modport master (
        output req_valid, req_port, req_out_vc, credit_avail,
        input  grant_valid, grant_vc, grant_out_port, credit_consume
    );

    modport slave (
        input  req_valid, req_port, req_out_vc, credit_avail,
        output grant_valid, grant_vc, grant_out_port, credit_consume
    );
endinterface

// File: rtl/sa_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr and
// returns the one-hot winner, its index and whether anything was granted.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    int   pos_s;
    logic hit_s;

    // Scan N positions from ptr; the first requester encountered wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        pos_s = 0;
        hit_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s      = (int'(ptr) + k) % N;
            hit_s      = !any && req[pos_s];
            gnt[pos_s] = hit_s;
            idx        = hit_s ? IW'(pos_s) : idx;
            any        = any | hit_s;
        end
    end
endmodule

// File: rtl/sa_rr_scheduler.sv
// Two-stage separable input-first switch allocator, credit-gated, RR at both
// stages, one-cycle latency. Define SA_AGE_EN for starvation-age override.
module sa_rr_scheduler
    import sa_rr_scheduler_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int NUM_VC    = NUM_VC_DEF,
    parameter int AGE_MAX   = AGE_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    sa_rr_scheduler_if.slave   sa
);
    localparam int PORT_BITS = $clog2(NUM_PORTS);
    localparam int VC_BITS   = $clog2(NUM_VC);

    logic [NUM_PORTS-1:0][NUM_VC-1:0]    elig_s;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]    s1_gnt_s;
    logic [NUM_PORTS-1:0][VC_BITS-1:0]   s1_idx_s;
    logic [NUM_PORTS-1:0]                s1_any_s;
    logic [NUM_PORTS-1:0][PORT_BITS-1:0] cand_port_s;
    logic [NUM_PORTS-1:0][VC_BITS-1:0]   cand_vc_s;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] s2_req_s;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] rr_gnt_s;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] s2_gnt_s;
    logic [NUM_PORTS-1:0][PORT_BITS-1:0] rr_idx_s;
    logic [NUM_PORTS-1:0][PORT_BITS-1:0] s2_idx_s;
    logic [NUM_PORTS-1:0]                s2_any_s;
    logic [NUM_PORTS-1:0]                win_s;
    logic [NUM_PORTS-1:0][VC_BITS-1:0]   gvc_next_s;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gop_next_s;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]    cc_next_s;

    logic [NUM_PORTS-1:0]                grant_valid_r;
    logic [NUM_PORTS-1:0][VC_BITS-1:0]   grant_vc_r;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant_out_port_r;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]    credit_consume_r;
    logic [NUM_PORTS-1:0][VC_BITS-1:0]   in_ptr_r;
    logic [NUM_PORTS-1:0][PORT_BITS-1:0] out_ptr_r;

    // Eligibility: valid, in-range target port, and a credit on the target out VC.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (sa.req_valid[i][v] && (int'(sa.req_port[i][v]) < NUM_PORTS)) begin
                    elig_s[i][v] = sa.credit_avail[sa.req_port[i][v]][sa.req_out_vc[i][v]];
                end else begin
                    elig_s[i][v] = 1'b0;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_arb
            rr_arbiter #(.N(NUM_VC), .IW(VC_BITS)) u_s1 (
                .req (elig_s[g]),
                .ptr (in_ptr_r[g]),
                .gnt (s1_gnt_s[g]),
                .idx (s1_idx_s[g]),
                .any (s1_any_s[g])
            );
            rr_arbiter #(.N(NUM_PORTS), .IW(PORT_BITS)) u_s2 (
                .req (s2_req_s[g]),
                .ptr (out_ptr_r[g]),
                .gnt (rr_gnt_s[g]),
                .idx (rr_idx_s[g]),
                .any (s2_any_s[g])
            );
        end
    endgenerate

    // Stage-1 candidate per input, then stage-2 request matrix indexed [output][input].
    always_comb begin
        cand_port_s = '0;
        cand_vc_s   = '0;
        s2_req_s    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int v = 0; v < NUM_VC; v++) begin
                cand_port_s[i] = cand_port_s[i] | (s1_gnt_s[i][v] ? sa.req_port[i][v] : '0);
                cand_vc_s[i]   = cand_vc_s[i] | (s1_gnt_s[i][v] ? sa.req_out_vc[i][v] : '0);
            end
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                s2_req_s[o][i] = s1_any_s[i] && (cand_port_s[i] == PORT_BITS'(o));
            end
        end
    end

`ifdef SA_AGE_EN
    localparam int AGE_BITS = $clog2(AGE_MAX + 1);

    logic [NUM_PORTS-1:0][AGE_BITS-1:0] age_r;
    logic [NUM_PORTS-1:0]               aged_s;
    logic                               take_s;

    // Starved inputs override the RR pointer; descending scan leaves the lowest aged index.
    always_comb begin
        s2_gnt_s = rr_gnt_s;
        s2_idx_s = rr_idx_s;
        take_s   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            aged_s[i] = (age_r[i] == AGE_BITS'(AGE_MAX));
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                take_s      = s2_req_s[o][i] && aged_s[i];
                s2_gnt_s[o] = take_s ? (NUM_PORTS'(1) << i) : s2_gnt_s[o];
                s2_idx_s[o] = take_s ? PORT_BITS'(i) : s2_idx_s[o];
            end
        end
    end

    // Age counts enabled cycles with an eligible VC but no grant, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_r <= '0;
        end else if (enable) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (win_s[i]) begin
                    age_r[i] <= '0;
                end else if (s1_any_s[i] && !aged_s[i]) begin
                    age_r[i] <= age_r[i] + 1'b1;
                end
            end
        end
    end
`else
    assign s2_gnt_s = rr_gnt_s;
    assign s2_idx_s = rr_idx_s;
`endif

    // Next-cycle grant outputs and the per-out-VC credit consume pulses.
    always_comb begin
        win_s      = '0;
        gop_next_s = '0;
        gvc_next_s = '0;
        cc_next_s  = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                win_s[i]         = win_s[i] | s2_gnt_s[o][i];
                gop_next_s[i][o] = s2_gnt_s[o][i];
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            gvc_next_s[i] = win_s[i] ? s1_idx_s[i] : '0;
            cc_next_s[cand_port_s[i]][cand_vc_s[i]] =
                cc_next_s[cand_port_s[i]][cand_vc_s[i]] | win_s[i];
        end
    end

    // Grant registers and RR pointers; a frozen pipeline holds grants but
    // drops the consume pulse so a credit is never charged twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_valid_r    <= '0;
            grant_vc_r       <= '0;
            grant_out_port_r <= '0;
            credit_consume_r <= '0;
            in_ptr_r         <= '0;
            out_ptr_r        <= '0;
        end else if (enable) begin
            grant_valid_r    <= win_s;
            grant_vc_r       <= gvc_next_s;
            grant_out_port_r <= gop_next_s;
            credit_consume_r <= cc_next_s;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (win_s[i]) begin
                    in_ptr_r[i] <= VC_BITS'(wrap_inc(int'(s1_idx_s[i]), NUM_VC));
                end
            end
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (s2_any_s[o]) begin
                    out_ptr_r[o] <= PORT_BITS'(wrap_inc(int'(s2_idx_s[o]), NUM_PORTS));
                end
            end
        end else begin
            credit_consume_r <= '0;
        end
    end

    assign sa.grant_valid    = grant_valid_r;
    assign sa.grant_vc       = grant_vc_r;
    assign sa.grant_out_port = grant_out_port_r;
    assign sa.credit_consume = credit_consume_r;

endmodule
